// File: rtl/jtbubl_sdram_arb_pkg.sv
// Shared constants for the Bubble Bobble SDRAM slot arbiter.
package jtbubl_sdram_pkg;

    localparam int unsigned NSLOTS = 5;

    localparam logic [2:0] SLOT_MAIN = 3'd0;
    localparam logic [2:0] SLOT_SUB  = 3'd1;
    localparam logic [2:0] SLOT_MCU  = 3'd2;
    localparam logic [2:0] SLOT_SND  = 3'd3;
    localparam logic [2:0] SLOT_GFX  = 3'd4;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_ACK = 2'd1;
    localparam logic [1:0] WAIT_RDY = 2'd2;

    // Slot index reached by stepping 'step' places past 'base', wrapping at NSLOTS.
    function automatic logic [2:0] rr_slot(input logic [2:0] base, input int unsigned step);
        int unsigned s;
        s = {29'd0, base} + step;
        return 3'(s % NSLOTS);
    endfunction

endpackage

// File: rtl/jtbubl_sdram_arb_if.sv
// SDRAM controller side of the ROM slot arbiter.
interface jtbubl_sdram_arb_if;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic        data_rdy;
    logic [31:0] data_read;
    logic        refresh_en;

    modport master (
        output sdram_req, sdram_addr, refresh_en,
        input  sdram_ack, data_rdy, data_read
    );

    modport slave (
        input  sdram_req, sdram_addr, refresh_en,
        output sdram_ack, data_rdy, data_read
    );
endinterface

// File: rtl/jtbubl_slot_cache.sv
// One-entry read cache for a single ROM consumer.
module jtbubl_slot_cache #(
    parameter int unsigned AW = 18,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          fill,
    input  logic [AW-1:0] fill_tag,
    input  logic [31:0]   fill_data,
    output logic          ok,
    output logic [DW-1:0] dout
);
    logic          valid_q, valid_d;
    logic [AW-1:0] tag_q, tag_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] fill_sel;

    // 8-bit slots pick the byte of the 16-bit SDRAM word addressed by the tag LSB.
    generate
        if (DW == 8) begin : g_byte
            logic unused_hi;
            assign unused_hi = ^fill_data[31:16];
            assign fill_sel  = fill_tag[0] ? fill_data[15:8] : fill_data[7:0];
        end else begin : g_word
            assign fill_sel = fill_data[DW-1:0];
        end
    endgenerate

    // Next cache contents: clear wins over fill.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (clr) begin
            valid_d = 1'b0;
        end else if (fill) begin
            valid_d = 1'b1;
            tag_d   = fill_tag;
            data_d  = fill_sel;
        end
    end

    // Cache registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign ok   = cs & valid_q & (addr == tag_q);
    assign dout = data_q;

endmodule

// File: rtl/jtbubl_sdram_arb.sv
// Round-robin arbiter sharing the SDRAM read port among five cached ROM slots.
module jtbubl_sdram_arb
    import jtbubl_sdram_pkg::*;
#(
    parameter logic [21:0] SUB_OFFSET = 22'h1_4000,
    parameter logic [21:0] SND_OFFSET = 22'h1_8000,
    parameter logic [21:0] MCU_OFFSET = 22'h1_C000,
    parameter logic [21:0] GFX_OFFSET = 22'h2_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        main_cs,
    input  logic [17:0] main_addr,
    output logic        main_ok,
    output logic [7:0]  main_dout,
    input  logic        sub_cs,
    input  logic [14:0] sub_addr,
    output logic        sub_ok,
    output logic [7:0]  sub_dout,
    input  logic        mcu_cs,
    input  logic [11:0] mcu_addr,
    output logic        mcu_ok,
    output logic [7:0]  mcu_dout,
    input  logic        snd_cs,
    input  logic [14:0] snd_addr,
    output logic        snd_ok,
    output logic [7:0]  snd_dout,
    input  logic        gfx_cs,
    input  logic [17:0] gfx_addr,
    output logic        gfx_ok,
    output logic [31:0] gfx_dout,
    input  logic        downloading,
    input  logic        loop_rst,
    jtbubl_sdram_arb_if.master sdr
);
    logic [1:0]  state_q, state_d;
    logic [2:0]  slot_q, slot_d;
    logic [2:0]  last_q, last_d;
    logic [17:0] tag_q, tag_d;
    logic [21:0] addr_q, addr_d;
    logic        req_q, req_d;

    logic [4:0]  cs_v, ok_v, pending, fill_v;
    logic        halt, found;
    logic [2:0]  pick, idx;
    logic [17:0] pick_tag;
    logic [21:0] pick_addr;

    assign halt    = downloading | loop_rst;
    assign cs_v    = {gfx_cs, snd_cs, mcu_cs, sub_cs, main_cs};
    assign ok_v    = {gfx_ok, snd_ok, mcu_ok, sub_ok, main_ok};
    assign pending = cs_v & ~ok_v;

    // Round-robin search starting at the slot after the last one served.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        idx   = last_q;
        for (int unsigned k = 1; k <= NSLOTS; k++) begin
            idx = rr_slot(last_q, k);
            if (!found && pending[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // SDRAM word address and cache tag for the selected slot.
    always_comb begin
        pick_tag  = '0;
        pick_addr = '0;
        case (pick)
            SLOT_MAIN: begin
                pick_tag  = main_addr;
                pick_addr = {5'd0, main_addr[17:1]};
            end
            SLOT_SUB: begin
                pick_tag  = {3'd0, sub_addr};
                pick_addr = SUB_OFFSET + {8'd0, sub_addr[14:1]};
            end
            SLOT_MCU: begin
                pick_tag  = {6'd0, mcu_addr};
                pick_addr = MCU_OFFSET + {11'd0, mcu_addr[11:1]};
            end
            SLOT_SND: begin
                pick_tag  = {3'd0, snd_addr};
                pick_addr = SND_OFFSET + {8'd0, snd_addr[14:1]};
            end
            SLOT_GFX: begin
                pick_tag  = gfx_addr;
                pick_addr = GFX_OFFSET + {3'd0, gfx_addr, 1'b0};
            end
            default: ;
        endcase
    end

    // Request FSM; a download/loop reset abandons any read in flight.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        last_d  = last_q;
        tag_d   = tag_q;
        addr_d  = addr_q;
        req_d   = req_q;
        fill_v  = '0;
        if (halt) begin
            state_d = IDLE;
            req_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (found) begin
                    slot_d  = pick;
                    tag_d   = pick_tag;
                    addr_d  = pick_addr;
                    req_d   = 1'b1;
                    state_d = WAIT_ACK;
                end
                WAIT_ACK: if (sdr.sdram_ack) begin
                    req_d   = 1'b0;
                    state_d = WAIT_RDY;
                end
                WAIT_RDY: if (sdr.data_rdy) begin
                    fill_v[slot_q] = 1'b1;
                    last_d         = slot_q;
                    state_d        = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM and request registers; pointer resets to the last slot so main goes first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            slot_q  <= SLOT_MAIN;
            last_q  <= SLOT_GFX;
            tag_q   <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            last_q  <= last_d;
            tag_q   <= tag_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
        end
    end

    assign sdr.sdram_req  = req_q;
    assign sdr.sdram_addr = addr_q;
    assign sdr.refresh_en = (state_q == IDLE) & ~|pending;

    jtbubl_slot_cache #(.AW(18), .DW(8)) u_main (
        .clk(clk), .rst_n(rst_n), .clr(halt), .cs(main_cs), .addr(main_addr),
        .fill(fill_v[0]), .fill_tag(tag_q), .fill_data(sdr.data_read),
        .ok(main_ok), .dout(main_dout)
    );

    jtbubl_slot_cache #(.AW(15), .DW(8)) u_sub (
        .clk(clk), .rst_n(rst_n), .clr(halt), .cs(sub_cs), .addr(sub_addr),
        .fill(fill_v[1]), .fill_tag(tag_q[14:0]), .fill_data(sdr.data_read),
        .ok(sub_ok), .dout(sub_dout)
    );

    jtbubl_slot_cache #(.AW(12), .DW(8)) u_mcu (
        .clk(clk), .rst_n(rst_n), .clr(halt), .cs(mcu_cs), .addr(mcu_addr),
        .fill(fill_v[2]), .fill_tag(tag_q[11:0]), .fill_data(sdr.data_read),
        .ok(mcu_ok), .dout(mcu_dout)
    );

    jtbubl_slot_cache #(.AW(15), .DW(8)) u_snd (
        .clk(clk), .rst_n(rst_n), .clr(halt), .cs(snd_cs), .addr(snd_addr),
        .fill(fill_v[3]), .fill_tag(tag_q[14:0]), .fill_data(sdr.data_read),
        .ok(snd_ok), .dout(snd_dout)
    );

    jtbubl_slot_cache #(.AW(18), .DW(32)) u_gfx (
        .clk(clk), .rst_n(rst_n), .clr(halt), .cs(gfx_cs), .addr(gfx_addr),
        .fill(fill_v[4]), .fill_tag(tag_q), .fill_data(sdr.data_read),
        .ok(gfx_ok), .dout(gfx_dout)
    );

endmodule

// File: tb/tb_jtbubl_sdram_arb.sv
// Directed bench for the SDRAM slot arbiter: vector table plus corner sequences.
module tb_jtbubl_sdram_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  cs;
    logic [17:0] a [5];
    logic        downloading, loop_rst;

    logic        main_ok, sub_ok, mcu_ok, snd_ok, gfx_ok;
    logic [7:0]  main_dout, sub_dout, mcu_dout, snd_dout;
    logic [31:0] gfx_dout;

    jtbubl_sdram_arb_if sdr();

    jtbubl_sdram_arb #(
        .SUB_OFFSET(22'h1_4000), .SND_OFFSET(22'h1_8000),
        .MCU_OFFSET(22'h1_C000), .GFX_OFFSET(22'h2_0000)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .main_cs(cs[0]), .main_addr(a[0]),        .main_ok(main_ok), .main_dout(main_dout),
        .sub_cs(cs[1]),  .sub_addr(a[1][14:0]),   .sub_ok(sub_ok),   .sub_dout(sub_dout),
        .mcu_cs(cs[2]),  .mcu_addr(a[2][11:0]),   .mcu_ok(mcu_ok),   .mcu_dout(mcu_dout),
        .snd_cs(cs[3]),  .snd_addr(a[3][14:0]),   .snd_ok(snd_ok),   .snd_dout(snd_dout),
        .gfx_cs(cs[4]),  .gfx_addr(a[4]),         .gfx_ok(gfx_ok),   .gfx_dout(gfx_dout),
        .downloading(downloading), .loop_rst(loop_rst),
        .sdr(sdr)
    );

    typedef struct {
        logic [2:0]  slot;
        logic [17:0] addr;
        logic [31:0] data;
        logic [21:0] exp_addr;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t tbl [7];
    logic [21:0] fair_addr [5];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [4:0] okb();
        return {gfx_ok, snd_ok, mcu_ok, sub_ok, main_ok};
    endfunction

    function automatic logic [31:0] dout_of(input logic [2:0] s);
        case (s)
            3'd0:    return {24'd0, main_dout};
            3'd1:    return {24'd0, sub_dout};
            3'd2:    return {24'd0, mcu_dout};
            3'd3:    return {24'd0, snd_dout};
            default: return gfx_dout;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 10 && sdr.sdram_req !== 1'b1; i++) tick();
        check(name, {31'd0, sdr.sdram_req}, 32'd1);
    endtask

    task automatic ack_cycle();
        sdr.sdram_ack = 1'b1;
        tick();
        sdr.sdram_ack = 1'b0;
    endtask

    task automatic rdy_cycle(input logic [31:0] d);
        sdr.data_read = d;
        sdr.data_rdy  = 1'b1;
        tick();
        sdr.data_rdy  = 1'b0;
        sdr.data_read = '0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [4:0] o;
        cs[v.slot] = 1'b1;
        a[v.slot]  = v.addr;
        #1;
        o = okb();
        check("vec_miss_ok", {31'd0, o[v.slot]}, 32'd0);
        tick();
        check("vec_req_rise", {31'd0, sdr.sdram_req}, 32'd1);
        check("vec_sdram_addr", {10'd0, sdr.sdram_addr}, {10'd0, v.exp_addr});
        check("vec_refresh_busy", {31'd0, sdr.refresh_en}, 32'd0);
        ack_cycle();
        check("vec_req_fall", {31'd0, sdr.sdram_req}, 32'd0);
        rdy_cycle(v.data);
        o = okb();
        check("vec_ok_after_fill", {31'd0, o[v.slot]}, 32'd1);
        check("vec_dout", dout_of(v.slot), v.exp_dout);
        check("vec_refresh_idle", {31'd0, sdr.refresh_en}, 32'd1);
        cs = '0;
        tick();
    endtask

    initial begin
        logic [4:0] o;
        cs = '0;
        for (int i = 0; i < 5; i++) a[i] = '0;
        downloading   = 1'b0;
        loop_rst      = 1'b0;
        sdr.sdram_ack = 1'b0;
        sdr.data_rdy  = 1'b0;
        sdr.data_read = '0;

        tbl[0] = '{3'd0, 18'h00003, 32'h0000_BEEF, 22'h000001, 32'h0000_00BE};
        tbl[1] = '{3'd1, 18'h00010, 32'h0000_A55A, 22'h014008, 32'h0000_005A};
        tbl[2] = '{3'd2, 18'h000FF, 32'h0000_C33C, 22'h01C07F, 32'h0000_00C3};
        tbl[3] = '{3'd3, 18'h07FFF, 32'hFFFF_1E2D, 22'h01BFFF, 32'h0000_001E};
        tbl[4] = '{3'd4, 18'h00010, 32'h1234_5678, 22'h020020, 32'h1234_5678};
        tbl[5] = '{3'd0, 18'h3FFFE, 32'h0000_7788, 22'h01FFFF, 32'h0000_0088};
        tbl[6] = '{3'd4, 18'h3FFFF, 32'hDEAD_BEEF, 22'h09FFFE, 32'hDEAD_BEEF};
        fair_addr[0] = 22'h000080;
        fair_addr[1] = 22'h014080;
        fair_addr[2] = 22'h01C080;
        fair_addr[3] = 22'h018080;
        fair_addr[4] = 22'h020200;

        // Reset values
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_req", {31'd0, sdr.sdram_req}, 32'd0);
        check("rst_addr", {10'd0, sdr.sdram_addr}, 32'd0);
        check("rst_ok", {27'd0, okb()}, 32'd0);
        check("rst_refresh", {31'd0, sdr.refresh_en}, 32'd1);
        check("rst_main_dout", dout_of(3'd0), 32'd0);
        check("rst_gfx_dout", dout_of(3'd4), 32'd0);

        // Address mapping and fill latency per slot
        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        // Hits: same-cycle ok, cached data, no new request
        cs[0] = 1'b1; a[0] = 18'h3FFFE;
        cs[4] = 1'b1; a[4] = 18'h3FFFF;
        #1;
        check("hit_ok", {27'd0, okb()}, 32'h11);
        check("hit_main_dout", dout_of(3'd0), 32'h88);
        check("hit_gfx_dout", dout_of(3'd4), 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hit_no_req", {31'd0, sdr.sdram_req}, 32'd0);
        end
        a[0] = 18'h00003;
        #1;
        check("stale_tag_miss", {31'd0, main_ok}, 32'd0);
        cs = '0;
        tick();

        // Fairness: all five pending, served in order main..gfx
        cs = 5'b11111;
        for (int i = 0; i < 5; i++) a[i] = 18'h00100;
        #1;
        check("fair_refresh_pending", {31'd0, sdr.refresh_en}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            wait_req("fair_req");
            check("fair_grant_addr", {10'd0, sdr.sdram_addr}, {10'd0, fair_addr[k]});
            check("fair_refresh_busy", {31'd0, sdr.refresh_en}, 32'd0);
            ack_cycle();
            rdy_cycle(32'h40 + 32'(k));
            o = okb();
            check("fair_slot_ok", {31'd0, o[k]}, 32'd1);
        end
        check("fair_all_ok", {27'd0, okb()}, 32'h1F);
        check("fair_refresh_done", {31'd0, sdr.refresh_en}, 32'd1);
        check("fair_snd_dout", dout_of(3'd3), 32'h43);
        cs = '0;
        tick();

        // Sub address changes while the read is in flight
        cs[1] = 1'b1; a[1] = 18'h00010;
        tick();
        check("chg_req", {31'd0, sdr.sdram_req}, 32'd1);
        check("chg_addr", {10'd0, sdr.sdram_addr}, 32'h014008);
        ack_cycle();
        a[1] = 18'h00020;
        rdy_cycle(32'h0000_00AA);
        check("chg_sub_not_ok", {31'd0, sub_ok}, 32'd0);
        check("chg_idle_gap", {31'd0, sdr.sdram_req}, 32'd0);
        tick();
        check("chg_rereq", {31'd0, sdr.sdram_req}, 32'd1);
        check("chg_rereq_addr", {10'd0, sdr.sdram_addr}, 32'h014010);
        a[1] = 18'h00010;
        #1;
        check("chg_old_tag_hit", {31'd0, sub_ok}, 32'd1);
        check("chg_old_tag_dout", dout_of(3'd1), 32'hAA);
        ack_cycle();
        rdy_cycle(32'h0000_00BB);
        a[1] = 18'h00020;
        #1;
        check("chg_new_tag_hit", {31'd0, sub_ok}, 32'd1);
        check("chg_new_tag_dout", dout_of(3'd1), 32'hBB);
        cs = '0;
        tick();

        // Download asserted during WAIT_ACK
        cs[4] = 1'b1; a[4] = 18'h00100;
        cs[0] = 1'b1; a[0] = 18'h00200;
        #1;
        check("dl_gfx_hit_before", {31'd0, gfx_ok}, 32'd1);
        tick();
        check("dl_req", {31'd0, sdr.sdram_req}, 32'd1);
        check("dl_req_addr", {10'd0, sdr.sdram_addr}, 32'h000100);
        downloading = 1'b1;
        tick();
        check("dl_req_drop", {31'd0, sdr.sdram_req}, 32'd0);
        check("dl_ok_clear", {27'd0, okb()}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            sdr.sdram_ack = 1'b1;
            rdy_cycle(32'hFFFF_FFFF);
            sdr.sdram_ack = 1'b0;
            check("dl_no_req", {31'd0, sdr.sdram_req}, 32'd0);
            check("dl_no_ok", {27'd0, okb()}, 32'd0);
        end
        downloading = 1'b0;
        tick();
        check("dl_rereq", {31'd0, sdr.sdram_req}, 32'd1);
        check("dl_rereq_addr", {10'd0, sdr.sdram_addr}, 32'h020200);
        ack_cycle();
        rdy_cycle(32'hCAFE_F00D);
        check("dl_gfx_refill", gfx_dout, 32'hCAFE_F00D);
        wait_req("dl_main_req");
        check("dl_main_addr", {10'd0, sdr.sdram_addr}, 32'h000100);
        ack_cycle();
        rdy_cycle(32'h0000_0055);
        check("dl_both_ok", {27'd0, okb()}, 32'h11);
        loop_rst = 1'b1;
        tick();
        loop_rst = 1'b0;
        cs = '0;
        check("loop_rst_clear", {31'd0, main_ok | gfx_ok}, 32'd0);
        cs[0] = 1'b1;
        #1;
        check("loop_rst_main_miss", {31'd0, main_ok}, 32'd0);
        cs = '0;
        tick();

        // Asynchronous reset during WAIT_RDY
        cs[2] = 1'b1; a[2] = 18'h00300;
        tick();
        check("rst2_req_addr", {10'd0, sdr.sdram_addr}, 32'h01C180);
        ack_cycle();
        rst_n = 1'b0;
        cs = '0;
        #1;
        check("rst2_req", {31'd0, sdr.sdram_req}, 32'd0);
        check("rst2_addr", {10'd0, sdr.sdram_addr}, 32'd0);
        check("rst2_refresh", {31'd0, sdr.refresh_en}, 32'd1);
        check("rst2_gfx_dout", dout_of(3'd4), 32'd0);
        check("rst2_sub_dout", dout_of(3'd1), 32'd0);
        sdr.data_read = 32'h0000_7777;
        sdr.data_rdy  = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        sdr.data_rdy = 1'b0;
        cs[2] = 1'b1;
        #1;
        check("rst2_late_rdy_ignored", {27'd0, okb()}, 32'd0);
        cs = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
